// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// A single full-subtractor cell and one borrow flop; the result is valid on the cycle done is high.
module serial_sub #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_acc;
  logic [N-1:0]   r_diff;
  logic           r_bw;
  logic           r_bout;
  logic [CW-1:0]  r_cnt;

  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_bw_next;
  logic w_last;
  logic w_accept;

  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_bw;
  assign w_bw_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bw);
  assign w_last    = (r_cnt == CW'(N - 1));
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_diff  <= '0;
      r_bw    <= 1'b0;
      r_bout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_bw  <= borrow_in;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_acc <= {w_d, r_acc[N-1:1]};
        r_bw  <= w_bw_next;
        // Counter stops at N-1 so it never wraps; the next accept reloads it.
        if (!w_last) r_cnt <= r_cnt + 1'b1;
        // The visible result only changes when a full word has been produced.
        if (w_last) begin
          r_diff <= {w_d, r_acc[N-1:1]};
          r_bout <= w_bw_next;
        end
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table, multi-cycle corner sequences,
// and unsigned random sweeps at N=4 and N=8.
module tb_serial_sub;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow_out;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;

  int checks   = 0;
  int failures = 0;

  logic [3:0] prev_d;
  logic       prev_bo;

  serial_sub #(.N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_sub #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation on the N=4 instance with latency, busy-length, hold and pulse-width checks.
  task automatic run_op4(input string tag, input logic [3:0] op_a, input logic [3:0] op_b,
                         input logic op_bin, input logic [3:0] exp_d, input logic exp_bo);
    int n;
    int busy_cnt;
    logic got;
    @(negedge clk);
    a = op_a; b = op_b; borrow_in = op_bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~op_a; b = ~op_b; borrow_in = ~op_bin;
    n = 1; busy_cnt = 0; got = 1'b0;
    while (n <= 20 && !got) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (n == 2) begin
          check({tag, " hold_diff"}, 32'(diff), 32'(prev_d));
          check({tag, " hold_bout"}, 32'(borrow_out), 32'(prev_bo));
          start = 1'b1;
        end
        if (n == 3) start = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(n), 32'd5);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, " diff"}, 32'(diff), 32'(exp_d));
    check({tag, " bout"}, 32'(borrow_out), 32'(exp_bo));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    prev_d  = exp_d;
    prev_bo = exp_bo;
  endtask

  task automatic run_op8(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_bin);
    int n;
    logic got;
    logic [8:0] exp;
    exp = {1'b0, op_a} - {1'b0, op_b} - {8'd0, op_bin};
    @(negedge clk);
    a8 = op_a; b8 = op_b; bin8 = op_bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~op_a; b8 = ~op_b;
    n = 1; got = 1'b0;
    while (n <= 30 && !got) begin
      if (done8) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("n8 done_seen", 32'(got), 32'd1);
    check("n8 latency", 32'(n), 32'd9);
    check("n8 diff", 32'(diff8), 32'(exp[7:0]));
    check("n8 bout", 32'(bout8), 32'(exp[8]));
  endtask

  initial begin
    int n;
    int done_cnt;
    logic got;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rbin;
    logic [4:0] exp5;

    vecs[0] = '{a: 4'b0101, b: 4'b0011, bin: 1'b0, d: 4'b0010, bo: 1'b0};
    vecs[1] = '{a: 4'b0011, b: 4'b0101, bin: 1'b0, d: 4'b1110, bo: 1'b1};
    vecs[2] = '{a: 4'b0000, b: 4'b0000, bin: 1'b1, d: 4'b1111, bo: 1'b1};
    vecs[3] = '{a: 4'b1111, b: 4'b0000, bin: 1'b0, d: 4'b1111, bo: 1'b0};
    vecs[4] = '{a: 4'b1000, b: 4'b0111, bin: 1'b1, d: 4'b0000, bo: 1'b0};
    vecs[5] = '{a: 4'b0000, b: 4'b0001, bin: 1'b0, d: 4'b1111, bo: 1'b1};
    vecs[6] = '{a: 4'b1010, b: 4'b0101, bin: 1'b1, d: 4'b0100, bo: 1'b0};
    vecs[7] = '{a: 4'b0111, b: 4'b0111, bin: 1'b1, d: 4'b1111, bo: 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    prev_d = '0; prev_bo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(borrow_out), 32'd0);

    // Directed table.
    for (int i = 0; i < 8; i++)
      run_op4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo);

    // Back-to-back: start held high, new operands in each DONE cycle, junk during RUN.
    @(negedge clk);
    a = vecs[0].a; b = vecs[0].b; borrow_in = vecs[0].bin; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0; got = 1'b0;
      while (n < 20 && !got) begin
        @(negedge clk);
        n++;
        if (done) got = 1'b1;
        else begin
          a = 4'($urandom); b = 4'($urandom); borrow_in = 1'($urandom);
        end
      end
      check($sformatf("b2b%0d done_seen", k), 32'(got), 32'd1);
      check($sformatf("b2b%0d period", k), 32'(n), 32'd5);
      check($sformatf("b2b%0d diff", k), 32'(diff), 32'(vecs[k].d));
      check($sformatf("b2b%0d bout", k), 32'(borrow_out), 32'(vecs[k].bo));
      if (k < 3) begin
        a = vecs[k+1].a; b = vecs[k+1].b; borrow_in = vecs[k+1].bin;
      end else start = 1'b0;
    end
    @(negedge clk);
    prev_d = vecs[3].d; prev_bo = vecs[3].bo;

    // Reset after two bit edges aborts the operation.
    @(negedge clk);
    a = vecs[4].a; b = vecs[4].b; borrow_in = vecs[4].bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(borrow_out), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    prev_d = '0; prev_bo = 1'b0;
    run_op4("post_abort", vecs[6].a, vecs[6].b, vecs[6].bin, vecs[6].d, vecs[6].bo);

    // Random sweep, N=4.
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom);
      exp5 = {1'b0, ra} - {1'b0, rb} - {4'd0, rbin};
      run_op4("rand4", ra, rb, rbin, exp5[3:0], exp5[4]);
    end

    // Random sweep, N=8, plus the extreme corners.
    run_op8(8'h00, 8'hFF, 1'b1);
    run_op8(8'hFF, 8'hFE, 1'b1);
    for (int i = 0; i < 200; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
